// File: rtl/dct_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dct_pkg -- shared state encoding and default geometry for the DCT scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package dct_pkg;

  localparam int unsigned DCT_N  = 8;
  localparam int unsigned DCT_AW = 6;
  localparam int unsigned DCT_IW = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ROW  = 3'd2,
    ST_COL  = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dct_idx_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dct_idx_cnt -- clear/enable counter that wraps modulo 2**WIDTH
// Rev 1.0
// ----------------------------------------------------------------------------
module dct_idx_cnt
  import dct_pkg::*;
#(
  parameter int WIDTH = DCT_IW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Clear wins over enable so a state entry always restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/dct_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dct_sched -- sequences load, row pass, column pass and readout of one NxN block
// Rev 1.0
// ----------------------------------------------------------------------------
module dct_sched
  import dct_pkg::*;
#(
  parameter int  N  = DCT_N,
  parameter int  AW = DCT_AW,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ld_we,
  output logic [AW-1:0] ld_addr,
  output logic          eng_en,
  output logic          eng_pass,
  output logic [IW-1:0] eng_idx,
  input  logic          eng_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          done,
  output logic [10:0]   blk_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  state_e        state_q, state_d;
  logic          eng_en_q, eng_en_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic [10:0]   blk_cnt_q, blk_cnt_d;
  logic [AW-1:0] elem;
  logic [IW-1:0] idx;
  logic          ld_hs;
  logic          out_hs;
  logic          eng_ack;
  logic          enter;

  assign ld_hs   = (state_q == ST_LOAD) && in_valid;
  assign out_hs  = (state_q == ST_OUT) && out_ready;
  // pend_q only rises the cycle after eng_en, so a done coincident with the
  // command or arriving with nothing outstanding is dropped here.
  assign eng_ack = pend_q && eng_done;
  assign enter   = (state_d != state_q) && (state_d != ST_IDLE);

  dct_idx_cnt #(.WIDTH(AW)) u_elem_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (enter),
    .en    (ld_hs || out_hs),
    .cnt   (elem)
  );

  dct_idx_cnt #(.WIDTH(IW)) u_idx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (enter),
    .en    (eng_ack),
    .cnt   (idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      eng_en_q  <= 1'b0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      eng_en_q  <= eng_en_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)                         state_d = ST_LOAD;
      ST_LOAD: if (ld_hs && elem == LAST_ADDR)    state_d = ST_ROW;
      ST_ROW:  if (eng_ack && idx == LAST_IDX)    state_d = ST_COL;
      ST_COL:  if (eng_ack && idx == LAST_IDX)    state_d = ST_OUT;
      ST_OUT:  if (out_hs && elem == LAST_ADDR)   state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  // Commands are issued on pass entry and on each accepted completion.
  always_comb begin
    eng_en_d  = ((state_d == ST_ROW) || (state_d == ST_COL)) && (enter || eng_ack);
    pend_d    = (pend_q && !eng_done) || eng_en_q;
    done_d    = out_hs && (elem == LAST_ADDR);
    blk_cnt_d = blk_cnt_q + {10'd0, done_d};
  end

  always_comb begin
    busy      = 1'b0;
    in_ready  = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    eng_en    = 1'b0;
    eng_pass  = 1'b0;
    eng_idx   = '0;
    out_valid = 1'b0;
    out_addr  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    blk_cnt   = blk_cnt_q;
    if (rst_n) begin
      busy      = (state_q != ST_IDLE);
      in_ready  = (state_q == ST_LOAD);
      ld_we     = ld_hs;
      ld_addr   = (state_q == ST_LOAD) ? elem : '0;
      eng_en    = eng_en_q;
      eng_pass  = (state_q == ST_COL);
      eng_idx   = ((state_q == ST_ROW) || (state_q == ST_COL)) ? idx : '0;
      out_valid = (state_q == ST_OUT);
      out_addr  = (state_q == ST_OUT) ? elem : '0;
      out_last  = (state_q == ST_OUT) && (elem == LAST_ADDR);
      done      = done_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dct_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dct_sched -- block-level checks of dct_sched (N=8) plus an N=2 build for blk_cnt wrap
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dct_sched;

  localparam int N  = 8;
  localparam int NN = N * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, eng_done, out_ready;
  logic        busy, in_ready, ld_we, eng_en, eng_pass, out_valid, out_last, done;
  logic [5:0]  ld_addr, out_addr;
  logic [2:0]  eng_idx;
  logic [10:0] blk_cnt;

  logic        start2, in_valid2, eng_done2, out_ready2;
  logic        busy2, in_ready2, ld_we2, eng_en2, eng_pass2, out_valid2, out_last2, done2;
  logic [1:0]  ld_addr2, out_addr2;
  logic [0:0]  eng_idx2;
  logic [10:0] blk_cnt2;

  dct_sched #(.N(8), .AW(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .ld_we(ld_we), .ld_addr(ld_addr),
    .eng_en(eng_en), .eng_pass(eng_pass), .eng_idx(eng_idx), .eng_done(eng_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_last(out_last),
    .done(done), .blk_cnt(blk_cnt)
  );

  dct_sched #(.N(2), .AW(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2),
    .in_valid(in_valid2), .in_ready(in_ready2), .ld_we(ld_we2), .ld_addr(ld_addr2),
    .eng_en(eng_en2), .eng_pass(eng_pass2), .eng_idx(eng_idx2), .eng_done(eng_done2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_addr(out_addr2), .out_last(out_last2),
    .done(done2), .blk_cnt(blk_cnt2)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int exp_blk = 0;
  int t_start = 0;
  bit started = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ctl_outs();
    return {busy, in_ready, ld_we, eng_en, eng_pass, eng_idx,
            out_valid, out_addr, out_last, done};
  endfunction

  // One block: load, two engine passes of latency lat, readout, done cycle.
  task automatic run_block(input int lat, input int vmode, input int rmode,
                           input int stall_at, input int stall_len,
                           input bit spur, input int abort_idx, input bit chain);
    int k, g, ws;
    bit iv, orr;
    if (!started) begin
      start = 1'b1;
      #1;
      chk("idle_busy", busy, 0);
      t_start = cyc;
      tick();
    end
    started = 1'b0;
    start   = 1'b0;

    k = 0; g = 0;
    while (k < NN && g < 4 * NN) begin
      case (vmode)
        0:       iv = 1'b1;
        1:       iv = (g % 2 == 0);
        default: iv = 1'($urandom_range(0, 1));
      endcase
      in_valid = iv;
      eng_done = spur && (g == 2);
      #1;
      chk("ld_ready", in_ready, 1);
      chk("ld_we", ld_we, iv);
      if (iv) begin
        chk("ld_addr", ld_addr, k);
        k++;
      end
      chk("ld_eng_en", eng_en, 0);
      g++;
      tick();
    end
    if (k < NN) chk("ld_timeout", k, NN);
    in_valid = 1'($urandom_range(0, 1));
    eng_done = 1'b0;

    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) begin
        eng_done = spur && (lat > 1);
        start    = spur && (p == 0);
        #1;
        chk("eng_en", eng_en, 1);
        chk("eng_idx", eng_idx, i);
        chk("eng_pass", eng_pass, p);
        chk("eng_busy", busy, 1);
        chk("eng_ld_we", ld_we, 0);
        tick();
        if (p == 1 && i == abort_idx) begin
          rst_n = 1'b0; eng_done = 1'b1; start = 1'b0;
          #1;
          chk("rst_outs_low", ctl_outs(), 0);
          tick();
          rst_n = 1'b1;
          #1;
          chk("rst_outs_idle", ctl_outs(), 0);
          chk("rst_blk", blk_cnt, 0);
          exp_blk = 0;
          tick();
          eng_done = 1'b0;
          #1;
          chk("rst_pend_ign", ctl_outs(), 0);
          tick();
          return;
        end
        for (int w = 1; w <= lat; w++) begin
          eng_done = (w == lat);
          start    = spur && (p == 0) && ($urandom_range(0, 1) == 1);
          #1;
          chk("eng_hold_en", eng_en, 0);
          chk("eng_hold_idx", eng_idx, i);
          chk("eng_hold_pass", eng_pass, p);
          tick();
        end
      end
    end
    eng_done = 1'b0;
    start    = 1'b0;

    k = 0; g = 0; ws = 0;
    while (k < NN && g < 8 * NN) begin
      if (k == stall_at && ws < stall_len) begin
        orr = 1'b0;
        ws++;
      end else begin
        orr = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      out_ready = orr;
      #1;
      chk("out_valid", out_valid, 1);
      chk("out_addr", out_addr, k);
      chk("out_last", out_last, (k == NN - 1));
      chk("out_done", done, 0);
      if (orr) k++;
      g++;
      tick();
    end
    if (k < NN) chk("out_timeout", k, NN);

    exp_blk   = (exp_blk + 1) % 2048;
    out_ready = 1'($urandom_range(0, 1));
    start     = chain;
    started   = chain;
    #1;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("blk_cnt", blk_cnt, exp_blk);
    if (vmode == 0 && rmode == 0 && stall_len == 0)
      chk("latency", cyc - t_start + 1, 1 + NN + 2 * N * (lat + 1) + NN + 1);
    if (chain) t_start = cyc;
    tick();
    start = 1'b0;
    #1;
    chk("done_pulse", done, 0);
    chk("post_ready", in_ready, chain);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; eng_done = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; in_valid2 = 1'b0; eng_done2 = 1'b0; out_ready2 = 1'b0;

    tick();
    chk("rst_outs", ctl_outs(), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_idle_outs", ctl_outs(), 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    tick();

    run_block(1, 0, 0, 0, 0, 1'b0, -1, 1'b0);   // nominal, L=1
    run_block(1, 1, 0, 0, 0, 1'b0, -1, 1'b0);   // in_valid toggling
    run_block(2, 0, 0, 20, 5, 1'b0, -1, 1'b0);  // readout stall at 20
    run_block(3, 0, 0, 0, 0, 1'b1, -1, 1'b0);   // spurious done / start
    run_block(1, 0, 0, 0, 0, 1'b0, 3, 1'b0);    // reset in COL idx 3
    run_block(1, 0, 0, 0, 0, 1'b0, -1, 1'b0);   // full block after reset
    for (int b = 0; b < 4; b++)
      run_block(int'($urandom_range(1, 4)), 2, 1, int'($urandom_range(0, NN - 1)),
                int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, (b < 3));

    begin : g_wrap
      int  nd;
      int  last;
      int  c;
      bit  en_prev;
      nd = 0; last = 0; c = 0; en_prev = 1'b0;
      in_valid2 = 1'b1; out_ready2 = 1'b1; start2 = 1'b1;
      while (nd < 2048 && c < 40000) begin
        #1;
        if (done2) begin
          nd++;
          chk("d2_period", c - last, 17);
          chk("d2_blk", blk_cnt2, nd % 2048);
          last = c;
        end
        en_prev = eng_en2;
        tick();
        c++;
        eng_done2 = en_prev;
        start2    = done2;
      end
      if (nd < 2048) chk("d2_timeout", nd, 2048);
      chk("d2_wrap", blk_cnt2, 0);
      chk("d2_restart", busy2, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
